// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared constants and channel state type for the mutex merge
package mm_pkg;
   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      INFL = 2'd2
   } ch_state_t;
endpackage

// File: rtl/sync_id_fifo.sv
// rtl/sync_id_fifo.sv - in-order channel-id FIFO recording downstream issue order
module sync_id_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic [CW-1:0] count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   assign head = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         // Caller guarantees no push when full and no pop when empty.
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/sync_mutex_merge_n.sv
// rtl/sync_mutex_merge_n.sv - arbitrated N-channel drive/free merge onto one downstream handshake
module sync_mutex_merge_n
   import mm_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int DEPTH    = 4,
   parameter int ARB_MODE = 1,
   localparam int IDW     = (N_CH > 1) ? $clog2(N_CH) : 1,
   localparam int CW      = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] i_drive,
   output logic [N_CH-1:0] o_free,
   output logic            o_driveNext,
   output logic [IDW-1:0]  o_grantId,
   input  logic            i_freeNext,
   output logic [CW-1:0]   o_inflight,
   output logic [N_CH-1:0] o_pending,
   output logic [N_CH-1:0] o_errDrive,
   output logic            o_errFree
);
   ch_state_t       st [N_CH];
   logic [N_CH-1:0] req;
   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  grant_id;
   logic            grant_found;
   logic            issue;
   logic            pop;
   logic [IDW-1:0]  head;

   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         req[k]       = (st[k] == PEND) || ((st[k] == IDLE) && i_drive[k]);
         o_pending[k] = (st[k] == PEND);
      end
   end

   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      if (ARB_MODE == ARB_FIXED) begin
         for (int k = N_CH - 1; k >= 0; k--) begin
            if (req[k]) begin
               grant_found = 1'b1;
               grant_id    = IDW'(k);
            end
         end
      end else begin
         // Scan starts just after the last granted channel and wraps.
         for (int off = 1; off <= N_CH; off++) begin
            if (!grant_found && req[(int'(rr_ptr) + off) % N_CH]) begin
               grant_found = 1'b1;
               grant_id    = IDW'((int'(rr_ptr) + off) % N_CH);
            end
         end
      end
   end

   // Full blocks issue even if a pop happens in the same cycle.
   assign issue = grant_found && (o_inflight < CW'(DEPTH));
   assign pop   = i_freeNext && (o_inflight != '0);

   sync_id_fifo #(
      .DEPTH (DEPTH),
      .W     (IDW),
      .CW    (CW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (issue),
      .push_data (grant_id),
      .pop       (pop),
      .head      (head),
      .count     (o_inflight)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < N_CH; k++) st[k] <= IDLE;
         o_free      <= '0;
         o_driveNext <= 1'b0;
         o_grantId   <= '0;
         o_errDrive  <= '0;
         o_errFree   <= 1'b0;
         rr_ptr      <= IDW'(N_CH - 1);
      end else begin
         o_free      <= '0;
         o_driveNext <= issue;
         for (int k = 0; k < N_CH; k++) begin
            case (st[k])
               IDLE: begin
                  if (issue && grant_id == IDW'(k)) st[k] <= INFL;
                  else if (i_drive[k])              st[k] <= PEND;
               end
               PEND: begin
                  if (i_drive[k]) o_errDrive[k] <= 1'b1;
                  if (issue && grant_id == IDW'(k)) st[k] <= INFL;
               end
               INFL: begin
                  if (i_drive[k]) o_errDrive[k] <= 1'b1;
                  if (pop && head == IDW'(k)) st[k] <= IDLE;
               end
               default: st[k] <= IDLE;
            endcase
         end
         if (issue) begin
            o_grantId <= grant_id;
            if (ARB_MODE != ARB_FIXED) rr_ptr <= grant_id;
         end
         if (pop) o_free[head] <= 1'b1;
         if (i_freeNext && !pop) o_errFree <= 1'b1;
      end
   end
endmodule
